// File: rtl/cache_data_array_pkg.sv
// ----------------------------------------------------------------------------
// lc3b_types: types shared across the cache datapath.
//   lc3b_cache_line     - one 128-bit cache line
//   lc3b_byte_mask      - one byte-enable bit per byte of a cache line
//   lc3b_array_state_e  - init sequencer state of cache_data_array
// ----------------------------------------------------------------------------
package lc3b_types;

  typedef logic [127:0] lc3b_cache_line;
  typedef logic [15:0]  lc3b_byte_mask;

  // INIT: the array is being zeroed one entry per cycle; READY: usable.
  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } lc3b_array_state_e;

endpackage : lc3b_types

// File: rtl/cache_data_array_if.sv
// ----------------------------------------------------------------------------
// cache_data_array_if: request/response bundle of cache_data_array.
//   master (requester) drives : flush, wr, widx, wmask, wdata, rd, ridx
//                               [+ par_inject with CACHE_ARRAY_PARITY_EN]
//   slave (array) drives      : rdata, rvalid, ready, dbg_state, dbg_clr_idx
//                               [+ parity_err with CACHE_ARRAY_PARITY_EN]
//
// Handshake: there is no per-request backpressure. While ready=1 every edge
// with wr=1 performs a write and every edge with rd=1 performs a read whose
// result appears in rdata with rvalid=1 for exactly the following cycle.
// While ready=0 (init clear in progress) rd, wr and flush are ignored.
//
// Optional macro: CACHE_ARRAY_PARITY_EN adds par_inject / parity_err.
// ----------------------------------------------------------------------------
interface cache_data_array_if #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8
);
  import lc3b_types::*;

  localparam int IDXW = $clog2(DEPTH);
  localparam int MW   = WIDTH / 8;

  logic              flush;
  logic              wr;
  logic [IDXW-1:0]   widx;
  logic [MW-1:0]     wmask;
  logic [WIDTH-1:0]  wdata;
  logic              rd;
  logic [IDXW-1:0]   ridx;
  logic [WIDTH-1:0]  rdata;
  logic              rvalid;
  logic              ready;
  lc3b_array_state_e dbg_state;
  logic [IDXW-1:0]   dbg_clr_idx;
`ifdef CACHE_ARRAY_PARITY_EN
  logic              par_inject;
  logic              parity_err;

  modport master (
    output flush, wr, widx, wmask, wdata, rd, ridx, par_inject,
    input  rdata, rvalid, ready, dbg_state, dbg_clr_idx, parity_err
  );
  modport slave (
    input  flush, wr, widx, wmask, wdata, rd, ridx, par_inject,
    output rdata, rvalid, ready, dbg_state, dbg_clr_idx, parity_err
  );
`else
  modport master (
    output flush, wr, widx, wmask, wdata, rd, ridx,
    input  rdata, rvalid, ready, dbg_state, dbg_clr_idx
  );
  modport slave (
    input  flush, wr, widx, wmask, wdata, rd, ridx,
    output rdata, rvalid, ready, dbg_state, dbg_clr_idx
  );
`endif

endinterface : cache_data_array_if

// File: rtl/cache_data_array_byte_parity.sv
// ----------------------------------------------------------------------------
// byte_parity: per-byte even-parity generator.
//   data [WIDTH-1:0]   in  : line to protect / check
//   par  [WIDTH/8-1:0] out : par[b] = XOR of data[8b+7:8b], so each byte plus
//                            its parity bit holds an even number of ones
// Used both to generate stored parity and to check a line read back.
// ----------------------------------------------------------------------------
module byte_parity #(
  parameter int WIDTH = 128
) (
  input  logic [WIDTH-1:0]   data,
  output logic [WIDTH/8-1:0] par
);

  always_comb begin
    par = '0;
    for (int b = 0; b < WIDTH / 8; b++) begin
      par[b] = ^data[8*b +: 8];
    end
  end

endmodule : byte_parity

// File: rtl/cache_data_array.sv
// ----------------------------------------------------------------------------
// cache_data_array: DEPTH x WIDTH cache line store with byte-masked writes,
// a registered read port and a self-clearing init sequencer.
//   clk, rst : clock, synchronous active-high reset
//   bus      : cache_data_array_if.slave (see interface header)
// After reset or an accepted flush the sequencer zeroes one entry per cycle;
// ready rises on the edge that zeroes entry DEPTH-1. A write and a read to
// the same index on one edge return the merged (write-first) line.
// Optional macro CACHE_ARRAY_PARITY_EN: per-byte even parity stored with the
// data, par_inject corrupts it on write, parity_err is flagged with rvalid.
// ----------------------------------------------------------------------------
module cache_data_array
  import lc3b_types::*;
#(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8
) (
  input logic               clk,
  input logic               rst,
  cache_data_array_if.slave bus
);

  localparam int IDXW = $clog2(DEPTH);
  localparam int MW   = WIDTH / 8;

  lc3b_array_state_e state_q, state_d;
  logic [IDXW-1:0]   clr_idx_q, clr_idx_d;
  logic              rvalid_q, rvalid_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];

  logic [WIDTH-1:0]  wline;    // entry[widx] with the masked bytes replaced
  logic [WIDTH-1:0]  rline;    // what a read returns, bypassing a same-index write
  logic              same_idx;

  function automatic logic [WIDTH-1:0] merge_line(input logic [WIDTH-1:0] old_l,
                                                  input logic [WIDTH-1:0] new_l,
                                                  input logic [MW-1:0]    m);
    logic [WIDTH-1:0] r;
    r = old_l;
    for (int b = 0; b < MW; b++) begin
      if (m[b]) r[8*b +: 8] = new_l[8*b +: 8];
    end
    return r;
  endfunction

  assign same_idx = bus.wr && (bus.widx == bus.ridx);
  assign wline    = merge_line(mem_q[bus.widx], bus.wdata, bus.wmask);
  assign rline    = same_idx ? wline : mem_q[bus.ridx];

`ifdef CACHE_ARRAY_PARITY_EN
  logic [MW-1:0] par_q [DEPTH];
  logic [MW-1:0] par_d [DEPTH];
  logic [MW-1:0] wpar_gen, rpar_gen, wpar_line, rpar;
  logic          perr_q, perr_d;

  byte_parity #(.WIDTH(WIDTH)) u_wpar (.data(wline), .par(wpar_gen));
  byte_parity #(.WIDTH(WIDTH)) u_rpar (.data(rline), .par(rpar_gen));

  // Only written bytes take fresh (optionally inverted) parity.
  assign wpar_line = (par_q[bus.widx] & ~bus.wmask)
                   | ((wpar_gen ^ (bus.par_inject ? bus.wmask : '0)) & bus.wmask);
  assign rpar      = same_idx ? wpar_line : par_q[bus.ridx];
`endif

  // Next-state / storage update. Everything is held while rst=1 so reset
  // never disturbs storage; the registers below apply the reset values.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    rvalid_d  = 1'b0;
    rdata_d   = rdata_q;
    mem_d     = mem_q;
`ifdef CACHE_ARRAY_PARITY_EN
    par_d     = par_q;
    perr_d    = 1'b0;
`endif
    if (!rst) begin
      case (state_q)
        INIT: begin
          mem_d[clr_idx_q] = '0;
`ifdef CACHE_ARRAY_PARITY_EN
          par_d[clr_idx_q] = '0;
`endif
          clr_idx_d = clr_idx_q + 1'b1;
          if (clr_idx_q == IDXW'(DEPTH - 1)) state_d = READY;
        end
        READY: begin
          if (bus.flush) begin
            // Accepted flush drops any same-edge rd/wr.
            state_d   = INIT;
            clr_idx_d = '0;
          end else begin
            if (bus.wr) begin
              mem_d[bus.widx] = wline;
`ifdef CACHE_ARRAY_PARITY_EN
              par_d[bus.widx] = wpar_line;
`endif
            end
            if (bus.rd) begin
              rvalid_d = 1'b1;
              rdata_d  = rline;
`ifdef CACHE_ARRAY_PARITY_EN
              perr_d   = |(rpar_gen ^ rpar);
`endif
            end
          end
        end
        default: begin
          state_d   = INIT;
          clr_idx_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= INIT;
      clr_idx_q <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  // Storage has no reset: the init clear defines every entry.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef CACHE_ARRAY_PARITY_EN
  always_ff @(posedge clk) begin
    par_q <= par_d;
    if (rst) perr_q <= 1'b0;
    else     perr_q <= perr_d;
  end
  assign bus.parity_err = perr_q;
`endif

  assign bus.rdata       = rdata_q;
  assign bus.rvalid      = rvalid_q;
  assign bus.ready       = (state_q == READY);
  assign bus.dbg_state   = state_q;
  assign bus.dbg_clr_idx = clr_idx_q;

endmodule : cache_data_array

// File: tb/tb_cache_data_array.sv
// ----------------------------------------------------------------------------
// tb_cache_data_array: directed, table-driven bench for cache_data_array
// (WIDTH=128, DEPTH=8), plus hand-written sequences for init, flush,
// reset-during-clear and (with CACHE_ARRAY_PARITY_EN) parity injection.
// ----------------------------------------------------------------------------
module tb_cache_data_array;
  import lc3b_types::*;

  localparam int WIDTH = 128;
  localparam int DEPTH = 8;

  typedef struct {
    string        name;
    logic         wr;
    logic [2:0]   widx;
    logic [15:0]  wmask;
    logic [127:0] wdata;
    logic         rd;
    logic [2:0]   ridx;
    logic         exp_rvalid;
    logic [127:0] exp_rdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;
  vec_t vq[$];

  cache_data_array_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  cache_data_array #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush = 1'b0;
    bus.wr    = 1'b0;
    bus.widx  = '0;
    bus.wmask = '0;
    bus.wdata = '0;
    bus.rd    = 1'b0;
    bus.ridx  = '0;
`ifdef CACHE_ARRAY_PARITY_EN
    bus.par_inject = 1'b0;
`endif
  endtask

  task automatic add_vec(input string name, input logic wr, input logic [2:0] widx,
                         input logic [15:0] wmask, input logic [127:0] wdata,
                         input logic rd, input logic [2:0] ridx,
                         input logic exp_rvalid, input logic [127:0] exp_rdata);
    vec_t v;
    v.name = name; v.wr = wr; v.widx = widx; v.wmask = wmask; v.wdata = wdata;
    v.rd = rd; v.ridx = ridx; v.exp_rvalid = exp_rvalid; v.exp_rdata = exp_rdata;
    vq.push_back(v);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic read_idx(input logic [2:0] idx, input logic [127:0] exp, input string name);
    idle_inputs();
    bus.rd   = 1'b1;
    bus.ridx = idx;
    step();
    check({name, "_rvalid"}, 128'(bus.rvalid), 128'd1);
    check({name, "_rdata"}, bus.rdata, exp);
    idle_inputs();
  endtask

  // ready must stay 0 for DEPTH-1 edges and rise on the DEPTH-th.
  task automatic check_clear(input string name);
    for (int i = 0; i < DEPTH; i++) begin
      step();
      check({name, "_ready"}, 128'(bus.ready), 128'(i == DEPTH - 1));
      check({name, "_rvalid"}, 128'(bus.rvalid), 128'd0);
    end
  endtask

  localparam logic [127:0] LINE_A5  = {16{8'hA5}};
  localparam logic [127:0] LINE_A53 = {{15{8'hA5}}, 8'h3C};
  localparam logic [127:0] LINE_B47 = 128'h0000_0000_0000_0000_FFFF_FFFF_0000_0000;
  localparam logic [127:0] LINE_SEQ = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] LINE_M5  = 128'h0000_0000_0000_0000_FFFF_FFFF_0000_0077;
  localparam logic [127:0] ONES     = {128{1'b1}};

  initial begin
    idle_inputs();

    // ---- reset held for two edges ----
    rst = 1'b1;
    step();
    step();
    check("rst_ready", 128'(bus.ready), 128'd0);
    check("rst_rvalid", 128'(bus.rvalid), 128'd0);
    check("rst_rdata", bus.rdata, 128'd0);
    check("rst_clr_idx", 128'(bus.dbg_clr_idx), 128'd0);
`ifdef CACHE_ARRAY_PARITY_EN
    check("rst_parity_err", 128'(bus.parity_err), 128'd0);
`endif

    // ---- init clear with rd held: reads ignored, ready after DEPTH edges ----
    rst      = 1'b0;
    bus.rd   = 1'b1;
    bus.ridx = 3'd1;
    check_clear("init");
    check("init_rdata_hold", bus.rdata, 128'd0);
    idle_inputs();

    // ---- table-driven READY-state vectors ----
    add_vec("rd_after_init", 0, 0, 16'h0000, 0,        1, 2, 1, 128'd0);
    add_vec("wr3_full",      1, 3, 16'hFFFF, LINE_A5,  0, 0, 0, 128'd0);
    add_vec("wr3_byte0",     1, 3, 16'h0001, {{15{8'hFF}}, 8'h3C}, 0, 0, 0, 128'd0);
    add_vec("rd3_merged",    0, 0, 16'h0000, 0,        1, 3, 1, LINE_A53);
    add_vec("idle_hold",     0, 0, 16'h0000, 0,        0, 0, 0, LINE_A53);
    add_vec("bypass5",       1, 5, 16'h00F0, ONES,     1, 5, 1, LINE_B47);
    add_vec("wr6_rd3_diff",  1, 6, 16'hFFFF, LINE_SEQ, 1, 3, 1, LINE_A53);
    add_vec("rd6",           0, 0, 16'h0000, 0,        1, 6, 1, LINE_SEQ);
    add_vec("wr7_nomask",    1, 7, 16'h0000, ONES,     0, 0, 0, LINE_SEQ);
    add_vec("rd7_zero",      0, 0, 16'h0000, 0,        1, 7, 1, 128'd0);
    add_vec("bypass5_b0",    1, 5, 16'h0001, {{15{8'h11}}, 8'h77}, 1, 5, 1, LINE_M5);
    add_vec("rd5_again",     0, 0, 16'h0000, 0,        1, 5, 1, LINE_M5);

    for (int i = 0; i < vq.size(); i++) begin
      bus.wr    = vq[i].wr;
      bus.widx  = vq[i].widx;
      bus.wmask = vq[i].wmask;
      bus.wdata = vq[i].wdata;
      bus.rd    = vq[i].rd;
      bus.ridx  = vq[i].ridx;
      step();
      check({vq[i].name, "_rvalid"}, 128'(bus.rvalid), 128'(vq[i].exp_rvalid));
      check({vq[i].name, "_rdata"}, bus.rdata, vq[i].exp_rdata);
    end
    idle_inputs();

    // ---- flush with same-edge write/read: both dropped ----
    bus.flush = 1'b1;
    bus.wr    = 1'b1;
    bus.widx  = 3'd0;
    bus.wmask = 16'hFFFF;
    bus.wdata = ONES;
    bus.rd    = 1'b1;
    bus.ridx  = 3'd3;
    step();
    check("flush_ready", 128'(bus.ready), 128'd0);
    check("flush_rvalid", 128'(bus.rvalid), 128'd0);
    check("flush_rdata_hold", bus.rdata, LINE_M5);
    idle_inputs();
    check_clear("flush_clear");
    for (int i = 0; i < DEPTH; i++) read_idx(3'(i), 128'd0, $sformatf("flush_rd%0d", i));

    // ---- reset at clr_idx=4 during a flush clear ----
    bus.wr    = 1'b1;
    bus.widx  = 3'd6;
    bus.wmask = 16'hFFFF;
    bus.wdata = LINE_SEQ;
    step();
    idle_inputs();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("mid_clr_idx4", 128'(bus.dbg_clr_idx), 128'd4);
    rst = 1'b1;
    step();
    check("midrst_clr_idx", 128'(bus.dbg_clr_idx), 128'd0);
    check("midrst_ready", 128'(bus.ready), 128'd0);
    rst = 1'b0;
    check_clear("midrst_clear");
    read_idx(3'd6, 128'd0, "midrst_rd6");

`ifdef CACHE_ARRAY_PARITY_EN
    // ---- parity injection and repair ----
    bus.wr = 1'b1; bus.widx = 3'd1; bus.wmask = 16'hFFFF; bus.wdata = LINE_SEQ;
    bus.par_inject = 1'b1;
    step();
    idle_inputs();
    read_idx(3'd1, LINE_SEQ, "par_inj_rd");
    check("par_inj_err", 128'(bus.parity_err), 128'd1);
    bus.wr = 1'b1; bus.widx = 3'd1; bus.wmask = 16'hFFFF; bus.wdata = LINE_SEQ;
    step();
    idle_inputs();
    read_idx(3'd1, LINE_SEQ, "par_fix_rd");
    check("par_fix_err", 128'(bus.parity_err), 128'd0);
    // Bypass: injected partial write read on the same edge.
    bus.wr = 1'b1; bus.widx = 3'd2; bus.wmask = 16'h0100; bus.wdata = ONES;
    bus.par_inject = 1'b1; bus.rd = 1'b1; bus.ridx = 3'd2;
    step();
    idle_inputs();
    check("par_byp_rdata", bus.rdata, 128'h0000_0000_0000_00FF_0000_0000_0000_0000);
    check("par_byp_err", 128'(bus.parity_err), 128'd1);
    step();
    check("par_idle_err", 128'(bus.parity_err), 128'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_cache_data_array
